dmem_unit: RTL and testbench
============================

# dmem_unit

Parametrised data-memory unit for the RV32 core's MEM stage. Decodes RISC-V load/store size (funct3), steers byte lanes, and sign- or zero-extends load data. Flags misaligned, out-of-range and illegal accesses instead of silently dropping them. Adds a valid/ready request/response handshake with configurable read latency, so the pipeline can stall on memory.

## Interface
- ADDR_WIDTH, 32: byte-address width.
- DATA_WIDTH, 32: word width; fixed at 32 for RV32, and elaboration fails otherwise.
- MEM_WORDS, 1024: depth in 32-bit words; must be a power of two.
- LATENCY, 1: cycles from request acceptance to `resp_valid`; legal range 1..8.
- clk  in  1  clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and memory.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (rs2).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and for faulted accesses.
- resp_err  out  2  00 OK, 01 MISALIGNED, 10 OUT_OF_RANGE, 11 ILLEGAL.

## Operation
- Storage is `MEM_WORDS` x 32-bit words, indexed by `addr[log2(MEM_WORDS)+1:2]`; byte lane = `addr[1:0]`.
- Handshake: the unit accepts a request on a rising edge with `req_valid && req_ready`. Only one request is outstanding at a time.
- Error checks are evaluated at acceptance, in priority order:
  - ILLEGAL: load funct3 in {011, 110, 111}, or store funct3 > 010.
  - MISALIGNED: H/HU with `addr[0] != 0`, or W with `addr[1:0] != 0`.
  - OUT_OF_RANGE: `addr >= MEM_WORDS*4`.
- Store without error: on the acceptance edge, write the enabled lanes only.
  - SB: lane `addr[1:0]` gets `wdata[7:0]`.
  - SH: lanes `addr[1]*2` and `addr[1]*2+1` get `wdata[15:0]`.
  - SW: all four lanes.
- Store with error: no write.
- Load without error: the selected word is snapshotted on the acceptance edge, then extracted and extended.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Load with error: `resp_rdata = 0`.
- Every request, store or load, faulted or not, produces exactly one response.
- FSM (states in the package):
  - IDLE: `req_ready = 1`. On accept, go to WAIT with `cnt = LATENCY-1`; if `LATENCY == 1`, go directly to RESP.
  - WAIT: decrement `cnt`; go to RESP when `cnt == 1`.
  - RESP: `resp_valid = 1`; output fields stay stable until `resp_ready`. On `resp_valid && resp_ready`, go to IDLE.
- No back-to-back acceptance in the RESP→IDLE cycle; `req_ready` rises the cycle after the response handshake.
- Reset mid-operation: the outstanding response is discarded and the FSM returns to IDLE. Memory is cleared to zero; a store accepted on the reset edge has no effect.

## Timing
- Reset values: `req_ready = 1`, `resp_valid = 0`, `resp_rdata = 0`, `resp_err = 00`.
- Store write is visible to a load accepted in any later cycle.
- `resp_valid` rises exactly `LATENCY` cycles after the acceptance edge; all outputs are registered.
- Throughput: one access per `LATENCY+1` cycles when `resp_ready` is held high.
- `resp_ready` held low keeps RESP and the response fields indefinitely; `req_ready` stays 0 meanwhile.

## Structure
- `dmem_pkg`:
  - funct3 localparams: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - `dmem_err_e`: OK, MISALIGNED, OUT_OF_RANGE, ILLEGAL.
  - `dmem_state_e`: IDLE, WAIT, RESP.
- Sub-module `dmem_align`: purely combinational.
  - Outputs the error code and write byte-enables/shifted wdata from funct3, `addr[1:0]`, wdata.
  - Also performs load extraction and extension from the raw word.
  - Instantiated once in `dmem_unit`.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → `resp_rdata = 0xDEADBEEF`, err 00, `resp_valid` exactly LATENCY cycles after accept. Run with LATENCY = 1 and 3.
- SB 0x80 @0x21, then LB @0x21 → 0xFFFFFF80. LBU @0x21 → 0x00000080. LW @0x20 → 0x00008000.
- SH 0x1234 @0x32, then LH @0x32 → 0x00001234. LHU @0x30 → 0x00000000 (lanes 0–1 untouched).
- LW @0x13 → err 01, rdata 0. SW @0x1002 with MEM_WORDS = 1024 → err 01 (misaligned outranks range). SW @0x1000 → err 10, no write. Load funct3 = 011 → err 11.
- Hold `resp_ready = 0` for 5 cycles → `resp_valid` and rdata stable, `req_ready = 0`. Release → handshake, `req_ready = 1` next cycle.
- Assert reset while in WAIT after SW 0xFF @0x0 → `resp_valid = 0`, `req_ready = 1`. A following LW @0x0 returns 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the RV32 data-memory unit
package dmem_pkg;

    // RV32 load/store size encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Latency counter width; covers LATENCY up to 8
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OK           = 2'b00,
        MISALIGNED   = 2'b01,
        OUT_OF_RANGE = 2'b10,
        ILLEGAL      = 2'b11
    } dmem_err_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - access checking, store lane steering and load extension
module dmem_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        oor_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output dmem_err_e   err_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic        illegal;
    logic        misaligned;
    logic [31:0] shifted;

    // Classify the access, then steer store lanes or extract load data
    always_comb begin
        err_o      = OK;
        be_o       = 4'b0000;
        wdata_o    = 32'h0;
        rdata_o    = 32'h0;
        shifted    = rword_i >> {addr_lo_i, 3'b000};
        illegal    = we_i ? (funct3_i > F3_W)
                          : !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = 1'b0;

        if (funct3_i == F3_H || funct3_i == F3_HU) begin
            misaligned = addr_lo_i[0];
        end else if (funct3_i == F3_W) begin
            misaligned = (addr_lo_i != 2'b00);
        end

        // Priority: illegal encoding, then alignment, then address range
        if (illegal) begin
            err_o = ILLEGAL;
        end else if (misaligned) begin
            err_o = MISALIGNED;
        end else if (oor_i) begin
            err_o = OUT_OF_RANGE;
        end

        if (err_o == OK) begin
            if (we_i) begin
                // Replicate the data across lanes so the enables alone pick the target bytes
                case (funct3_i)
                    F3_B: begin
                        be_o    = 4'b0001 << addr_lo_i;
                        wdata_o = {4{wdata_i[7:0]}};
                    end
                    F3_H: begin
                        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                        wdata_o = {2{wdata_i[15:0]}};
                    end
                    default: begin
                        be_o    = 4'b1111;
                        wdata_o = wdata_i;
                    end
                endcase
            end else begin
                case (funct3_i)
                    F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
                    F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
                    F3_BU:   rdata_o = {24'h0, shifted[7:0]};
                    F3_HU:   rdata_o = {16'h0, shifted[15:0]};
                    default: rdata_o = rword_i;
                endcase
            end
        end
    end

endmodule

// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - RV32 MEM-stage data memory with request/response handshake
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_err
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    if (DATA_WIDTH != 32) begin : g_chk_dw
        $error("dmem_unit: DATA_WIDTH must be 32");
    end
    if ((1 << IDX_W) != MEM_WORDS) begin : g_chk_words
        $error("dmem_unit: MEM_WORDS must be a power of two");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_chk_lat
        $error("dmem_unit: LATENCY must be in 1..8");
    end
    if (ADDR_WIDTH < IDX_W + 2) begin : g_chk_aw
        $error("dmem_unit: ADDR_WIDTH too small for MEM_WORDS");
    end

    logic [31:0]      mem_q [MEM_WORDS];
    dmem_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic [31:0]      resp_rdata_q;
    dmem_err_e        resp_err_q;

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic             oor;
    dmem_err_e        a_err;
    logic [3:0]       a_be;
    logic [31:0]      a_wdata;
    logic [31:0]      a_rdata;

    assign accept     = req_valid && req_ready_q;
    assign idx        = req_addr[IDX_W+1:2];
    assign oor        = (req_addr >> (IDX_W + 2)) != '0;

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    dmem_align u_align (
        .we_i      (req_we),
        .funct3_i  (req_funct3),
        .addr_lo_i (req_addr[1:0]),
        .oor_i     (oor),
        .wdata_i   (req_wdata),
        .rword_i   (mem_q[idx]),
        .err_o     (a_err),
        .be_o      (a_be),
        .wdata_o   (a_wdata),
        .rdata_o   (a_rdata)
    );

    // Storage: cleared by reset, byte-lane write on an accepted fault-free store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (accept && req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b]) begin
                    mem_q[idx][8*b +: 8] <= a_wdata[8*b +: 8];
                end
            end
        end
    end

    // Handshake FSM; the response is captured at acceptance and held until consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= OK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_ready_q  <= 1'b0;
                        resp_rdata_q <= a_rdata;
                        resp_err_q   <= a_err;
                        if (LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// tb/tb_dmem_unit.sv - directed self-checking bench for dmem_unit
module tb_dmem_unit;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    logic        d1_req_valid, d1_req_ready, d1_req_we;
    logic [2:0]  d1_req_funct3;
    logic [31:0] d1_req_addr, d1_req_wdata;
    logic        d1_resp_valid, d1_resp_ready;
    logic [31:0] d1_resp_rdata;
    logic [1:0]  d1_resp_err;

    int errors = 0;
    int checks = 0;

    dmem_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024), .LATENCY(3)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_we(d1_req_we),
        .req_funct3(d1_req_funct3), .req_addr(d1_req_addr), .req_wdata(d1_req_wdata),
        .resp_valid(d1_resp_valid), .resp_ready(d1_resp_ready),
        .resp_rdata(d1_resp_rdata), .resp_err(d1_resp_err)
    );

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic [1:0] err, output int lat);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_wait got=0 exp=1");
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
        rdata = resp_rdata;
        err   = resp_err;
        if (!resp_valid) begin
            checks++; errors++;
            $display("FAIL resp_valid_wait got=0 exp=1 addr=%h", addr);
        end
        @(posedge clk);
    endtask

    task automatic do_req1(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic [1:0] err, output int lat);
        int n = 0;
        @(negedge clk);
        while (!d1_req_ready && n < 50) begin @(negedge clk); n++; end
        if (!d1_req_ready) begin
            checks++; errors++;
            $display("FAIL d1_req_ready_wait got=0 exp=1");
        end
        d1_req_valid = 1'b1; d1_req_we = we; d1_req_funct3 = f3;
        d1_req_addr = addr; d1_req_wdata = wdata;
        @(posedge clk);
        #1 d1_req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!d1_resp_valid && lat < 20);
        rdata = d1_resp_rdata;
        err   = d1_resp_err;
        if (!d1_resp_valid) begin
            checks++; errors++;
            $display("FAIL d1_resp_valid_wait got=0 exp=1 addr=%h", addr);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
        checks++; if (resp_err !== 2'b00) begin errors++; $display("FAIL rst_resp_err got=%b exp=00", resp_err); end
        checks++; if (d1_req_ready !== 1'b1) begin errors++; $display("FAIL rst_d1_req_ready got=%b exp=1", d1_req_ready); end
        checks++; if (d1_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_d1_resp_valid got=%b exp=0", d1_resp_valid); end
        reset = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic [1:0] er; int lat;
        do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checks++; if (er !== 2'b00) begin errors++; $display("FAIL sw_err got=%b exp=00", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata got=%h exp=0", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency got=%0d exp=3", lat); end
        do_req(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd); end
        checks++; if (er !== 2'b00) begin errors++; $display("FAIL lw_err got=%b exp=00", er); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_latency1();
        logic [31:0] rd; logic [1:0] er; int lat;
        do_req1(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL l1_sw_latency got=%0d exp=1", lat); end
        do_req1(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL l1_lw_rdata got=%h exp=deadbeef", rd); end
        checks++; if (er !== 2'b00) begin errors++; $display("FAIL l1_lw_err got=%b exp=00", er); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL l1_lw_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic [1:0] er; int lat;
        do_req(1'b1, F3_B, 32'h21, 32'hAAAAAA80, rd, er, lat);
        checks++; if (er !== 2'b00) begin errors++; $display("FAIL sb_err got=%b exp=00", er); end
        do_req(1'b0, F3_B, 32'h21, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got=%h exp=ffffff80", rd); end
        do_req(1'b0, F3_BU, 32'h21, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got=%h exp=00000080", rd); end
        do_req(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00008000) begin errors++; $display("FAIL lw_byte_word got=%h exp=00008000", rd); end
        do_req(1'b1, F3_B, 32'h23, 32'h1234567F, rd, er, lat);
        do_req(1'b0, F3_B, 32'h23, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0000007F) begin errors++; $display("FAIL lb_pos_rdata got=%h exp=0000007f", rd); end
        do_req(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h7F008000) begin errors++; $display("FAIL lw_byte_word2 got=%h exp=7f008000", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic [1:0] er; int lat;
        do_req(1'b1, F3_H, 32'h32, 32'hFFFF1234, rd, er, lat);
        checks++; if (er !== 2'b00) begin errors++; $display("FAIL sh_err got=%b exp=00", er); end
        do_req(1'b0, F3_H, 32'h32, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lh_rdata got=%h exp=00001234", rd); end
        do_req(1'b0, F3_HU, 32'h30, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00000000) begin errors++; $display("FAIL lhu_low_rdata got=%h exp=00000000", rd); end
        do_req(1'b1, F3_H, 32'h30, 32'h00008001, rd, er, lat);
        do_req(1'b0, F3_H, 32'h30, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_neg_rdata got=%h exp=ffff8001", rd); end
        do_req(1'b0, F3_HU, 32'h30, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_rdata got=%h exp=00008001", rd); end
        do_req(1'b0, F3_W, 32'h30, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h12348001) begin errors++; $display("FAIL lw_half_word got=%h exp=12348001", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic [1:0] er; int lat;
        do_req(1'b0, F3_W, 32'h13, 32'h0, rd, er, lat);
        checks++; if (er !== 2'b01) begin errors++; $display("FAIL lw_mis_err got=%b exp=01", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lw_mis_rdata got=%h exp=0", rd); end
        do_req(1'b0, F3_H, 32'h33, 32'h0, rd, er, lat);
        checks++; if (er !== 2'b01) begin errors++; $display("FAIL lh_mis_err got=%b exp=01", er); end
        do_req(1'b1, F3_W, 32'h1002, 32'h55555555, rd, er, lat);
        checks++; if (er !== 2'b01) begin errors++; $display("FAIL sw_mis_oor_err got=%b exp=01", er); end
        do_req(1'b1, F3_W, 32'h1000, 32'h55555555, rd, er, lat);
        checks++; if (er !== 2'b10) begin errors++; $display("FAIL sw_oor_err got=%b exp=10", er); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sw_oor_latency got=%0d exp=3", lat); end
        do_req(1'b0, F3_W, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_no_write got=%h exp=0", rd); end
        do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
        checks++; if (er !== 2'b11) begin errors++; $display("FAIL ld_ill_err got=%b exp=11", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ld_ill_rdata got=%h exp=0", rd); end
        do_req(1'b1, F3_BU, 32'h10, 32'h0, rd, er, lat);
        checks++; if (er !== 2'b11) begin errors++; $display("FAIL st_ill_err got=%b exp=11", er); end
        do_req(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL st_ill_no_write got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_stall();
        int n = 0;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_wait got=%b exp=1", resp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, resp_valid); end
            checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_rdata[%0d] got=%h exp=deadbeef", i, resp_rdata); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d] got=%b exp=0", i, req_ready); end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got=%b exp=0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_back_to_back();
        int resp_cnt = 0;
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (resp_valid) resp_cnt++;
        end
        req_valid = 1'b0;
        checks++; if (resp_cnt !== 4) begin errors++; $display("FAIL b2b_responses got=%0d exp=4", resp_cnt); end
        while (!(req_ready && !resp_valid) && n < 20) begin @(negedge clk); n++; end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain got=%b exp=1", req_ready); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [1:0] er; int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h0; req_wdata = 32'h000000FF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_in_wait got=%b exp=0", req_ready); end
        reset = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        do_req(1'b0, F3_W, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_lw0 got=%h exp=0", rd); end
        do_req(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_mem_clear got=%h exp=0", rd); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        resp_ready = 1'b1;
        d1_req_valid = 1'b0; d1_req_we = 1'b0; d1_req_funct3 = 3'b0;
        d1_req_addr = 32'h0; d1_req_wdata = 32'h0;
        d1_resp_ready = 1'b1;
        test_reset();
        test_word();
        test_latency1();
        test_byte();
        test_half();
        test_errors();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
